// File: rtl/timer_countdown_param.sv
// BCD mm:ss countdown: keypad digits shift in, one decrement per tick, all outputs registered except zero.
// Strobes act in the cycle they appear (no backpressure); TIMER_ALARM_EN adds an alarm held ALARM_TICKS ticks after done.
module timer_countdown_param #(
  parameter int MIN_DIGITS  = 1,
  parameter int ALARM_TICKS = 3
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic [3:0]              data,
  input  logic                    digit_vld,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    tick,
  output logic [3:0]              so,
  output logic [3:0]              st,
  output logic [4*MIN_DIGITS-1:0] min,
  output logic                    zero,
  output logic                    running,
  output logic                    done,
  output logic                    alarm
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t                     r_state, w_nxt_state;
  logic [3:0]                 r_so, r_st;
  logic [3:0]                 w_nxt_so, w_nxt_st;
  logic [3:0]                 w_dec_so, w_dec_st;
  logic [MIN_DIGITS-1:0][3:0] r_min, w_nxt_min, w_dec_min, w_shf_min;
  logic                       r_running, r_done, w_nxt_done;
  logic                       w_is_one, w_key_ok;

  assign zero     = (r_so == 4'd0) && (r_st == 4'd0) && (r_min == '0);
  assign w_is_one = (r_so == 4'd1) && (r_st == 4'd0) && (r_min == '0);
  // A key is refused when it would push a units digit above 5 into the tens place.
  assign w_key_ok = digit_vld && (data <= 4'd9) && (r_so <= 4'd5);

  always_comb begin : p_dec
    logic w_borrow;
    w_dec_so = (r_so == 4'd0) ? 4'd9 : r_so - 4'd1;
    w_borrow = (r_so == 4'd0);
    w_dec_st = r_st;
    if (w_borrow) begin
      w_dec_st = (r_st == 4'd0) ? 4'd5 : r_st - 4'd1;
      w_borrow = (r_st == 4'd0);
    end
    w_dec_min = r_min;
    for (int i = 0; i < MIN_DIGITS; i++) begin
      if (w_borrow) begin
        w_dec_min[i] = (r_min[i] == 4'd0) ? 4'd9 : r_min[i] - 4'd1;
        w_borrow     = (r_min[i] == 4'd0);
      end
    end
  end

  always_comb begin
    w_shf_min    = r_min;
    w_shf_min[0] = r_st;
    for (int i = 1; i < MIN_DIGITS; i++) begin
      w_shf_min[i] = r_min[i-1];
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_so    = r_so;
    w_nxt_st    = r_st;
    w_nxt_min   = r_min;
    w_nxt_done  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (stop) begin
          w_nxt_so  = 4'd0;
          w_nxt_st  = 4'd0;
          w_nxt_min = '0;
        end else if (start && !zero) begin
          w_nxt_state = S_RUN;
        end else if (w_key_ok) begin
          w_nxt_so  = data;
          w_nxt_st  = r_so;
          w_nxt_min = w_shf_min;
        end
      end
      S_RUN: begin
        if (stop) begin
          w_nxt_state = S_PAUSE;
        end else if (tick && !zero) begin
          w_nxt_so  = w_dec_so;
          w_nxt_st  = w_dec_st;
          w_nxt_min = w_dec_min;
          if (w_is_one) begin
            w_nxt_state = S_DONE;
            w_nxt_done  = 1'b1;
          end
        end
      end
      S_PAUSE: begin
        if (stop) begin
          w_nxt_state = S_IDLE;
          w_nxt_so    = 4'd0;
          w_nxt_st    = 4'd0;
          w_nxt_min   = '0;
        end else if (start) begin
          w_nxt_state = S_RUN;
        end
      end
      S_DONE: begin
        if (start || stop) begin
          w_nxt_state = S_IDLE;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state   <= S_IDLE;
      r_so      <= 4'd0;
      r_st      <= 4'd0;
      r_min     <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_so      <= w_nxt_so;
      r_st      <= w_nxt_st;
      r_min     <= w_nxt_min;
      r_running <= (w_nxt_state == S_RUN);
      r_done    <= w_nxt_done;
    end
  end

  assign so      = r_so;
  assign st      = r_st;
  assign min     = r_min;
  assign running = r_running;
  assign done    = r_done;

`ifdef TIMER_ALARM_EN
  localparam int ACW = $clog2(ALARM_TICKS + 1);

  logic [ACW-1:0] r_alarm_cnt;
  logic           r_alarm;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_alarm     <= 1'b0;
      r_alarm_cnt <= '0;
    end else if (w_nxt_done) begin
      r_alarm     <= 1'b1;
      r_alarm_cnt <= '0;
    end else if (r_alarm) begin
      if (start || stop) begin
        r_alarm <= 1'b0;
      end else if (tick) begin
        if (r_alarm_cnt == ACW'(ALARM_TICKS - 1)) begin
          r_alarm <= 1'b0;
        end
        r_alarm_cnt <= r_alarm_cnt + 1'b1;
      end
    end
  end

  assign alarm = r_alarm;
`else
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_timer_countdown_param.sv
// Randomized and directed stimulus against an arithmetic (total-seconds) model; a monitor pops expected outputs each cycle.
module tb_timer_countdown_param;

  localparam int MD  = 2;
  localparam int AT  = 3;
  localparam int MOD = 10 ** MD;

  localparam int ST_IDLE  = 0;
  localparam int ST_RUN   = 1;
  localparam int ST_PAUSE = 2;
  localparam int ST_DONE  = 3;

  logic            clk = 1'b0;
  logic            clear = 1'b1;
  logic [3:0]      data = 4'd0;
  logic            digit_vld = 1'b0, start = 1'b0, stop = 1'b0, tick = 1'b0;
  logic [3:0]      so, st;
  logic [4*MD-1:0] min;
  logic            zero, running, done, alarm;

  timer_countdown_param #(.MIN_DIGITS(MD), .ALARM_TICKS(AT)) dut (
    .clk(clk), .clear(clear), .data(data), .digit_vld(digit_vld),
    .start(start), .stop(stop), .tick(tick),
    .so(so), .st(st), .min(min), .zero(zero),
    .running(running), .done(done), .alarm(alarm)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]      so;
    logic [3:0]      st;
    logic [4*MD-1:0] mn;
    logic            z, r, d, a;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Model: minutes and seconds as plain integers, state as a small integer.
  int m_state, m_mins, m_secs, m_acnt;
  bit m_done, m_alarm;

  function automatic exp_t model_out();
    exp_t e;
    int   p;
    e.so = 4'(m_secs % 10);
    e.st = 4'(m_secs / 10);
    p = 1;
    for (int i = 0; i < MD; i++) begin
      e.mn[4*i +: 4] = 4'((m_mins / p) % 10);
      p = p * 10;
    end
    e.z = (m_mins == 0 && m_secs == 0);
    e.r = (m_state == ST_RUN);
    e.d = m_done;
    e.a = m_alarm;
    return e;
  endfunction

  task automatic model_reset();
    m_state = ST_IDLE; m_mins = 0; m_secs = 0;
    m_done = 0; m_alarm = 0; m_acnt = 0;
  endtask

  task automatic model_step(input int d, input bit dv, input bit s, input bit p, input bit t);
    int tot;
    tot    = m_mins * 60 + m_secs;
    m_done = 0;
    if (m_alarm) begin
      if (s || p) m_alarm = 0;
      else if (t) begin
        m_acnt++;
        if (m_acnt >= AT) m_alarm = 0;
      end
    end
    case (m_state)
      ST_IDLE: begin
        if (p) begin
          m_mins = 0; m_secs = 0;
        end else if (s && tot != 0) begin
          m_state = ST_RUN;
        end else if (dv && d <= 9 && (m_secs % 10) <= 5) begin
          m_mins = (m_mins * 10 + m_secs / 10) % MOD;
          m_secs = (m_secs % 10) * 10 + d;
        end
      end
      ST_RUN: begin
        if (p) m_state = ST_PAUSE;
        else if (t && tot > 0) begin
          tot    = tot - 1;
          m_mins = tot / 60;
          m_secs = tot % 60;
          if (tot == 0) begin
            m_state = ST_DONE;
            m_done  = 1;
`ifdef TIMER_ALARM_EN
            m_alarm = 1;
            m_acnt  = 0;
`endif
          end
        end
      end
      ST_PAUSE: begin
        if (p) begin
          m_state = ST_IDLE; m_mins = 0; m_secs = 0;
        end else if (s) m_state = ST_RUN;
      end
      default: begin
        if (s || p) m_state = ST_IDLE;
      end
    endcase
  endtask

  task automatic check(input string tag, input exp_t e);
    n_vec++;
    if ({so, st, min, zero, running, done, alarm} !== e) begin
      n_err++;
      $display("FAIL %s @%0t: got so=%0d st=%0d min=%h zero=%b run=%b done=%b alarm=%b, expected so=%0d st=%0d min=%h zero=%b run=%b done=%b alarm=%b",
               tag, $time, so, st, min, zero, running, done, alarm,
               e.so, e.st, e.mn, e.z, e.r, e.d, e.a);
    end
  endtask

  task automatic cyc(input bit clr, input int d, input bit dv, input bit s, input bit p, input bit t);
    @(negedge clk);
    data = 4'(d); digit_vld = dv; start = s; stop = p; tick = t;
    if (clr) begin
      clear = 1'b1;
      model_reset();
      #1 check("async_clear", model_out());
    end else begin
      clear = 1'b0;
      model_step(d, dv, s, p, t);
    end
    q.push_back(model_out());
  endtask

  task automatic key(input int d);
    cyc(0, d, 1, 0, 0, 0);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("cycle", e);
      end
    end
  end

  initial begin : stim
    model_reset();
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);

    key(1); key(3); key(0);          // 1:30 -> min=01 st=3 so=0
    key(7); key(8);                  // 8 refused since so=7
    key(12);                         // data > 9 refused
    cyc(0, 0, 0, 1, 0, 0);           // start in IDLE with nonzero -> RUN
    ticks(2);
    cyc(0, 0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 1, 0);

    cyc(0, 0, 0, 1, 0, 0);           // start while zero: ignored
    key(1); key(0); key(0); key(0);  // 10:00
    cyc(0, 0, 0, 1, 0, 0);
    ticks(2);                        // 9:59, 9:58
    cyc(0, 0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 1, 0);

    key(1); key(0); key(0);          // 1:00 -> 0:59
    cyc(0, 0, 0, 1, 0, 0);
    ticks(1);
    idle_n(1);
    cyc(0, 0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 1, 0);

    key(2);                          // 0:02 to done, extra ticks hold 0:00
    cyc(0, 0, 0, 1, 0, 0);
    ticks(2);
    cyc(0, 0, 1, 0, 0, 1);           // digit ignored in DONE
    ticks(3);
    idle_n(2);
    cyc(0, 0, 0, 1, 0, 0);           // DONE -> IDLE

    key(3); key(0);                  // 0:30: stop+tick, resume, stop twice
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 1);
    ticks(2);
    cyc(0, 0, 0, 1, 0, 0);
    ticks(1);
    cyc(0, 0, 0, 1, 1, 1);           // stop beats start and tick
    cyc(0, 0, 0, 0, 1, 0);

    cyc(0, 4, 1, 0, 0, 1);           // tick with digit in IDLE
    key(5);
    cyc(0, 0, 0, 1, 0, 0);
    ticks(2);
    cyc(1, 0, 0, 0, 0, 0);           // async clear mid-RUN
    idle_n(1);

    key(1); key(0);                  // 0:10 to done with alarm window then stop
    cyc(0, 0, 0, 1, 0, 0);
    ticks(10);
    ticks(1);
    cyc(0, 0, 0, 0, 1, 0);

    for (int seg = 0; seg < 40; seg++) begin
      int nk;
      cyc(0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 1, 0);
      nk = ($urandom_range(0, 4) == 0) ? 3 : $urandom_range(1, 2);
      for (int k = 0; k < nk; k++) key($urandom_range(0, 10));
      cyc(0, 0, 0, 1, 0, 0);
      for (int c = 0; c < 150; c++) begin
        cyc(($urandom_range(0, 599) == 0),
            $urandom_range(0, 11),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 49) == 0),
            ($urandom_range(0, 1) == 1));
      end
    end

    @(negedge clk);
    clear = 1'b0; digit_vld = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #3;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected outputs left unchecked, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
